// File: rtl/util_input_conditioner.sv
// rtl/util_input_conditioner.sv - multi-channel synchroniser, glitch filter, edge detector and sticky interrupt flags
module util_input_conditioner #(
    parameter int NUM_CH        = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_CH-1:0]     din_i,
    input  logic [2*NUM_CH-1:0]   edge_sel_i,
    input  logic [NUM_CH-1:0]     flag_clr_i,
    input  logic [NUM_CH-1:0]     irq_en_i,
    output logic                  ready_o,
    output logic [NUM_CH-1:0]     level_o,
    output logic [NUM_CH-1:0]     rise_o,
    output logic [NUM_CH-1:0]     fall_o,
    output logic [NUM_CH-1:0]     event_o,
    output logic [NUM_CH-1:0]     event_flag_o,
    output logic                  irq_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(FILTER_CYCLES - 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       prime_q, prime_d;
    logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]   sample;
    logic [CW-1:0]       cnt_q [NUM_CH];
    logic [CW-1:0]       cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   level_q, level_d;
    logic [NUM_CH-1:0]   rise_q, rise_d;
    logic [NUM_CH-1:0]   fall_q, fall_d;
    logic [NUM_CH-1:0]   event_q, event_d;
    logic [NUM_CH-1:0]   flag_q, flag_d;
    logic                irq_q, irq_d;

    assign sample = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 captures the raw pins, the last stage is the sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '{default: '0};
        end else begin
            sync_q[0] <= din_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Priming/run control, filter counters, level, edge pulses, flags and irq
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_PRIME;
            prime_q <= '0;
            cnt_q   <= '{default: '0};
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            event_q <= '0;
            flag_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prime_q <= prime_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
            flag_q  <= flag_d;
            irq_q   <= irq_d;
        end
    end

    // Next state: priming loads level silently; running filters each channel independently
    always_comb begin
        state_d = state_q;
        prime_d = prime_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        event_d = '0;
        // A set from the current event pulse overrides a clear in the same cycle
        flag_d  = (flag_q & ~flag_clr_i) | event_q;
        irq_d   = |(flag_q & irq_en_i);

        case (state_q)
            ST_PRIME: begin
                if (prime_q == PRIME_LAST) begin
                    state_d = ST_RUN;
                    level_d = sample;
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_d[i] = '0;
                    end
                end else begin
                    prime_d = prime_q + PW'(1);
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sample[i] == level_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        level_d[i] = sample[i];
                        cnt_d[i]   = '0;
                        rise_d[i]  = sample[i];
                        fall_d[i]  = ~sample[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            event_d[i] = (rise_d[i] & edge_sel_i[2*i]) | (fall_d[i] & edge_sel_i[2*i+1]);
        end
    end

    assign ready_o      = (state_q == ST_RUN);
    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign event_o      = event_q;
    assign event_flag_o = flag_q;
    assign irq_o        = irq_q;

endmodule
